// File: rtl/seg7_pkg.sv
// ============================================================================
// Module   : seg7_pkg
// Purpose  : Segment patterns and converter state encoding shared by the
//            7-segment scan driver.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

package seg7_pkg;

   localparam logic [6:0] SEG_BLANK = 7'b1111111;
   localparam logic [6:0] SEG_DASH  = 7'b1111110;

   // {a,b,c,d,e,f,g}, active-low
   localparam logic [6:0] SEG_DIGIT [10] = '{
      7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110, 7'b1001100,
      7'b0100100, 7'b0100000, 7'b0001111, 7'b0000000, 7'b0000100
   };

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_SHIFT  = 2'd1,
      ST_COMMIT = 2'd2
   } conv_state_e;

   function automatic logic [63:0] pow10(input int n);
      logic [63:0] p;
      p = 64'd1;
      for (int i = 0; i < n; i++) p = p * 64'd10;
      return p;
   endfunction

endpackage

`default_nettype wire

// File: rtl/seg7_decode.sv
// ============================================================================
// Module   : seg7_decode
// Purpose  : 4-bit BCD to active-low 7-segment pattern; non-decimal codes blank.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module seg7_decode
   import seg7_pkg::*;
(
   input  logic [3:0] bcd_i,
   output logic [6:0] seg_o
);

   always_comb begin
      seg_o = SEG_BLANK;
      if (bcd_i <= 4'd9) seg_o = SEG_DIGIT[bcd_i];
   end

endmodule

`default_nettype wire

// File: rtl/seg7_scan_display.sv
// ============================================================================
// Module   : seg7_scan_display
// Purpose  : N-digit binary-to-decimal converter (sequential double-dabble)
//            driving a time-multiplexed common-anode 7-segment display.
//            Optional leading-zero blanking via macro SEG7_LZ_BLANK_EN.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module seg7_scan_display
   import seg7_pkg::*;
#(
   parameter int BIN_W       = 14,
   parameter int DIGITS      = 4,
   parameter int REFRESH_DIV = 65536
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [BIN_W-1:0]  num,
   input  logic              hold,
   output logic [6:0]        led,
   output logic [DIGITS-1:0] a,
   output logic              ovf,
   output logic              done
);

   localparam int BCD_W = 4 * DIGITS;
   localparam int SR_W  = BCD_W + BIN_W;
   localparam int CNT_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
   localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
   localparam int SH_W  = $clog2(BIN_W + 1);
   localparam logic [63:0] MAX_VAL = pow10(DIGITS) - 64'd1;

   conv_state_e       state_q, state_d;
   logic [SR_W-1:0]   sr_q, sr_d, sr_adj;
   logic [SH_W-1:0]   shcnt_q, shcnt_d;
   logic              ovfn_q, ovfn_d;
   logic [BCD_W-1:0]  disp_q, disp_d;
   logic              ovf_q, ovf_d;
   logic              done_q, done_d;
   logic [CNT_W-1:0]  pres_q, pres_d;
   logic [IDX_W-1:0]  idx_q, idx_d, idx_nxt;
   logic [6:0]        led_q, led_d;
   logic [DIGITS-1:0] a_q, a_d, a_nxt;
   logic              tick;
   logic [3:0]        sel_nib;
   logic [6:0]        dec_seg;
   logic              lz_blank;

   // ---------------------------------------------------------------- converter
   always_comb begin
      state_d = state_q;
      sr_d    = sr_q;
      shcnt_d = shcnt_q;
      ovfn_d  = ovfn_q;
      disp_d  = disp_q;
      ovf_d   = ovf_q;
      done_d  = 1'b0;

      sr_adj = sr_q;
      for (int i = 0; i < DIGITS; i++) begin
         if (sr_q[BIN_W + 4*i +: 4] >= 4'd5)
            sr_adj[BIN_W + 4*i +: 4] = sr_q[BIN_W + 4*i +: 4] + 4'd3;
      end

      case (state_q)
         ST_IDLE: begin
            sr_d    = {{BCD_W{1'b0}}, num};
            shcnt_d = '0;
            ovfn_d  = (64'(num) > MAX_VAL);
            state_d = ST_SHIFT;
         end
         ST_SHIFT: begin
            sr_d    = {sr_adj[SR_W-2:0], 1'b0};
            shcnt_d = shcnt_q + 1'b1;
            if (shcnt_q == SH_W'(BIN_W - 1)) state_d = ST_COMMIT;
         end
         ST_COMMIT: begin
            // A held commit drops this result; the next conversion retries.
            if (!hold) begin
               disp_d = sr_q[SR_W-1 -: BCD_W];
               ovf_d  = ovfn_q;
               done_d = 1'b1;
            end
            state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // ---------------------------------------------------------------- scanning
   always_comb begin
      tick    = (pres_q == CNT_W'(REFRESH_DIV - 1));
      pres_d  = tick ? '0 : pres_q + 1'b1;
      idx_nxt = (idx_q == IDX_W'(DIGITS - 1)) ? '0 : idx_q + 1'b1;
      idx_d   = tick ? idx_nxt : idx_q;
      sel_nib = 4'd0;
      a_nxt   = '1;
      for (int i = 0; i < DIGITS; i++) begin
         if (idx_nxt == IDX_W'(i)) begin
            sel_nib  = disp_q[4*i +: 4];
            a_nxt[i] = 1'b0;
         end
      end
   end

   seg7_decode u_decode (
      .bcd_i (sel_nib),
      .seg_o (dec_seg)
   );

`ifdef SEG7_LZ_BLANK_EN
   logic upper_zero;

   // A digit is blank when it and every digit above it are zero; digit 0 never.
   always_comb begin
      upper_zero = 1'b1;
      lz_blank   = 1'b0;
      for (int i = DIGITS - 1; i >= 1; i--) begin
         if (disp_q[4*i +: 4] != 4'd0) upper_zero = 1'b0;
         if (idx_nxt == IDX_W'(i)) lz_blank = upper_zero;
      end
   end
`else
   assign lz_blank = 1'b0;
`endif

   // disp_q/ovf_q are read before any same-edge commit lands.
   always_comb begin
      led_d = led_q;
      a_d   = a_q;
      if (tick) begin
         led_d = ovf_q ? SEG_DASH : (lz_blank ? SEG_BLANK : dec_seg);
         a_d   = a_nxt;
      end
   end

   // ---------------------------------------------------------------- registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         sr_q    <= '0;
         shcnt_q <= '0;
         ovfn_q  <= 1'b0;
         disp_q  <= '0;
         ovf_q   <= 1'b0;
         done_q  <= 1'b0;
         pres_q  <= '0;
         idx_q   <= '0;
         led_q   <= SEG_BLANK;
         a_q     <= '1;
      end else begin
         state_q <= state_d;
         sr_q    <= sr_d;
         shcnt_q <= shcnt_d;
         ovfn_q  <= ovfn_d;
         disp_q  <= disp_d;
         ovf_q   <= ovf_d;
         done_q  <= done_d;
         pres_q  <= pres_d;
         idx_q   <= idx_d;
         led_q   <= led_d;
         a_q     <= a_d;
      end
   end

   assign led  = led_q;
   assign a    = a_q;
   assign ovf  = ovf_q;
   assign done = done_q;

endmodule

`default_nettype wire

// File: tb/tb_seg7_scan_display.sv
// ============================================================================
// Module   : tb_seg7_scan_display
// Purpose  : Scoreboard bench for seg7_scan_display (BIN_W=14, DIGITS=4,
//            REFRESH_DIV=4); honours SEG7_LZ_BLANK_EN when defined.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_seg7_scan_display;

   localparam int BIN_W       = 14;
   localparam int DIGITS      = 4;
   localparam int REFRESH_DIV = 4;
   localparam int PERIOD      = BIN_W + 2;

   logic              clk   = 1'b0;
   logic              rst_n = 1'b0;
   logic              hold  = 1'b0;
   logic [BIN_W-1:0]  num   = '0;
   logic [6:0]        led;
   logic [DIGITS-1:0] a;
   logic              ovf;
   logic              done;

   seg7_scan_display #(
      .BIN_W       (BIN_W),
      .DIGITS      (DIGITS),
      .REFRESH_DIV (REFRESH_DIV)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .num   (num),
      .hold  (hold),
      .led   (led),
      .a     (a),
      .ovf   (ovf),
      .done  (done)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int passed = 0;
   int unsigned exp_q[$];

   localparam logic [6:0] PAT [10] = '{
      7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110, 7'b1001100,
      7'b0100100, 7'b0100000, 7'b0001111, 7'b0000000, 7'b0000100
   };

   task automatic check(input string name, input longint act, input longint exp);
      checks++;
      if (act == exp) passed++;
      else $display("FAIL %s: got %0d expected %0d", name, act, exp);
   endtask

   function automatic int unsigned pow10(input int n);
      int unsigned p = 1;
      for (int i = 0; i < n; i++) p = p * 10;
      return p;
   endfunction

   // Expected segments for digit position idx of a committed value v.
   function automatic logic [6:0] exp_led(input int unsigned v, input int idx);
      int unsigned p = pow10(idx);
      if (v > pow10(DIGITS) - 1) return 7'b1111110;
`ifdef SEG7_LZ_BLANK_EN
      if (idx > 0 && v < p) return 7'b1111111;
`endif
      return PAT[(v / p) % 10];
   endfunction

   // ---------------------------------------------------------------- monitor
   int unsigned       model_v;
   logic [DIGITS-1:0] prev_a;
   int                prev_idx, cyc, m_zeros, m_idx;
   bit                first;

   always @(negedge clk) begin
      if (!rst_n) begin
         model_v  = 0;
         prev_a   = '1;
         prev_idx = 0;
         cyc      = 0;
         first    = 1'b1;
      end else begin
         cyc++;
         if (a !== prev_a) begin
            m_zeros = 0;
            m_idx   = -1;
            for (int i = 0; i < DIGITS; i++)
               if (a[i] == 1'b0) begin
                  m_zeros++;
                  m_idx = i;
               end
            check("anode_onehot", m_zeros, 1);
            check("scan_index", m_idx, first ? (1 % DIGITS) : ((prev_idx + 1) % DIGITS));
            if (!first) check("tick_interval", cyc, REFRESH_DIV);
            check("led", led, exp_led(model_v, m_idx));
            prev_a   = a;
            prev_idx = m_idx;
            cyc      = 0;
            first    = 1'b0;
         end
         if (done === 1'b1) begin
            if (exp_q.size() == 0) check("unexpected_done", 1, 0);
            else model_v = exp_q.pop_front();
         end
         check("ovf", ovf, (model_v > pow10(DIGITS) - 1) ? 1 : 0);
      end
   end

   // ---------------------------------------------------------------- stimulus
   task automatic wait_done(input int bound, output int n);
      bit seen = 1'b0;
      n = 0;
      while (!seen && n < bound) begin
         @(negedge clk);
         n++;
         seen = (done === 1'b1);
      end
      if (!seen) check("done_timeout", 0, 1);
      #1;
   endtask

   task automatic apply(input int unsigned v);
      int n;
      num = BIN_W'(v);
      exp_q.push_back(v);
      wait_done(40, n);
      check("done_period", n, PERIOD);
   endtask

   task automatic hold_episode(input int unsigned v);
      int n;
      hold = 1'b1;
      num  = BIN_W'(v);
      repeat (40) @(negedge clk);
      #1;
      hold = 1'b0;
      exp_q.push_back(v);
      wait_done(32, n);
   endtask

   task automatic check_reset_outputs();
      check("rst_led", led, 7'h7F);
      check("rst_a", a, 4'hF);
      check("rst_ovf", ovf, 0);
      check("rst_done", done, 0);
   endtask

   int unsigned bvals[4] = '{9999, 10000, 0, 16383};

   initial begin
      int n;
      int r;
      num = 14'd1234;
      exp_q.push_back(1234);
      repeat (3) begin
         @(negedge clk);
         check_reset_outputs();
      end
      #1;
      rst_n = 1'b1;
      wait_done(40, n);
      check("first_latency", n, PERIOD);

      apply(9999);
      apply(10000);
      apply(0);
      apply(7);
      apply(42);
      hold_episode(77);
      apply(12000);

      // Reset in the middle of a conversion
      repeat (5) @(negedge clk);
      #1;
      rst_n = 1'b0;
      exp_q.delete();
      repeat (3) begin
         @(negedge clk);
         check_reset_outputs();
      end
      #1;
      num = 14'd5678;
      exp_q.push_back(5678);
      rst_n = 1'b1;
      wait_done(40, n);
      check("post_reset_latency", n, PERIOD);

      for (int it = 0; it < 30; it++) begin
         r = $urandom_range(0, 7);
         if (r == 0)      hold_episode($urandom_range(0, 16383));
         else if (r == 1) apply(bvals[$urandom_range(0, 3)]);
         else             apply($urandom_range(0, 16383));
      end

      repeat (8) @(negedge clk);
      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
      $fatal(1);
   end

endmodule

`default_nettype wire
